serial_comparator_multi_digit: RTL and testbench

//   Compares two WIDTH-bit numbers streamed in as DIGIT_W-bit digits, one digit per accepted beat.

---
 rtl/serial_comparator_multi_digit_if.sv | 25 ++
 rtl/serial_comparator_multi_digit.sv | 100 ++++++++++
 tb/tb_serial_comparator_multi_digit.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_comparator_multi_digit_if.sv
// Digit-stream bus for the multi-digit serial comparator: digit inputs, abort,
// and the registered busy/result outputs.
interface serial_comparator_multi_digit_if #(
  parameter int unsigned DIGIT_W = 2
);
  logic               abort;
  logic               in_valid;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic               busy;
  logic               res_valid;
  logic               a_less_b;
  logic               a_eq_b;
  logic               a_greater_b;

  modport master (
    output abort, in_valid, a, b,
    input  busy, res_valid, a_less_b, a_eq_b, a_greater_b
  );

  modport slave (
    input  abort, in_valid, a, b,
    output busy, res_valid, a_less_b, a_eq_b, a_greater_b
  );
endinterface

// File: rtl/serial_comparator_multi_digit.sv
// Compares two WIDTH-bit operands streamed as DIGIT_W-bit digits, MSB- or LSB-first,
// signed or unsigned, and strobes registered less/eq/greater flags one cycle after the last digit.
module serial_comparator_multi_digit #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIGIT_W   = 2,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          SIGNED    = 1'b0
) (
  input logic                           clk,
  input logic                           rst,
  serial_comparator_multi_digit_if.slave bus
);

  localparam int unsigned BEATS = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] MsdBeat  = MSB_FIRST ? '0 : LastBeat;

  typedef enum logic [1:0] {StEq, StLt, StGt} cmp_e;

  logic [CNT_W-1:0]   r_cnt;
  cmp_e               r_part;
  logic               r_busy;
  logic               r_res_valid;
  logic               r_lt;
  logic               r_eq;
  logic               r_gt;

  logic [CNT_W-1:0]   w_cnt;
  logic [CNT_W-1:0]   w_cnt_d;
  cmp_e               w_part;
  cmp_e               w_dig;
  cmp_e               w_part_d;
  logic               w_last;
  logic               w_final;
  logic [DIGIT_W-1:0] w_a;
  logic [DIGIT_W-1:0] w_b;

  always_comb begin
    w_a    = bus.a;
    w_b    = bus.b;
    // abort restarts the frame this cycle, so a coincident digit becomes beat 0
    w_cnt  = bus.abort ? '0 : r_cnt;
    w_part = bus.abort ? StEq : r_part;
    w_last = (w_cnt == LastBeat);

    if (w_a == w_b) begin
      w_dig = StEq;
    end else if (SIGNED && (w_cnt == MsdBeat)) begin
      w_dig = ($signed(w_a) < $signed(w_b)) ? StLt : StGt;
    end else begin
      w_dig = (w_a < w_b) ? StLt : StGt;
    end

    if (MSB_FIRST) begin
      w_part_d = (w_part == StEq) ? w_dig : w_part;
    end else begin
      w_part_d = (w_dig == StEq) ? w_part : w_dig;
    end

    w_final = bus.in_valid && w_last;
    w_cnt_d = w_cnt;
    if (bus.in_valid) begin
      w_cnt_d = w_last ? '0 : w_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_part      <= StEq;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_lt        <= 1'b0;
      r_eq        <= 1'b1;
      r_gt        <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_d;
      r_busy      <= (w_cnt_d != '0);
      r_res_valid <= w_final;
      if (w_final) begin
        r_part <= StEq;
        r_lt   <= (w_part_d == StLt);
        r_eq   <= (w_part_d == StEq);
        r_gt   <= (w_part_d == StGt);
      end else if (bus.in_valid) begin
        r_part <= w_part_d;
      end else begin
        r_part <= w_part;
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.res_valid   = r_res_valid;
  assign bus.a_less_b    = r_lt;
  assign bus.a_eq_b      = r_eq;
  assign bus.a_greater_b = r_gt;

endmodule

// File: tb/tb_serial_comparator_multi_digit.sv
// Bench for serial_comparator_multi_digit: 16 configurations (DIGIT_W 1/2/4/8, both digit
// orders, signed/unsigned) share one operand-level stimulus; directed scenarios plus random frames.
module tb_serial_comparator_multi_digit;

  logic        clk;
  logic        rst;
  logic        drv_valid;
  logic        drv_abort;
  logic [7:0]  drv_a;
  logic [7:0]  drv_b;
  int          drv_k;
  logic        cnt_clr;

  logic [15:0]      g_busy;
  logic [15:0]      g_rv;
  logic [15:0][2:0] g_flags;
  logic [15:0][7:0] g_rvc;

  int tests;
  int fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // g: DIGIT_W = 1 << (g % 4), MSB_FIRST = (g / 4) % 2, SIGNED = g / 8
  for (genvar g = 0; g < 16; g++) begin : g_cfg
    localparam int DW = 1 << (g % 4);
    localparam int NB = 8 / DW;
    localparam bit MF = ((g / 4) % 2) == 1;
    localparam bit SG = (g / 8) == 1;

    serial_comparator_multi_digit_if #(.DIGIT_W(DW)) ifc ();
    int         k_idx;
    logic [7:0] rvc;

    assign k_idx        = MF ? (NB - 1 - drv_k) : drv_k;
    assign ifc.in_valid = drv_valid && (drv_k < NB);
    assign ifc.abort    = drv_abort;
    assign ifc.a = (k_idx >= 0 && k_idx < NB) ? DW'(drv_a >> (k_idx * DW)) : '0;
    assign ifc.b = (k_idx >= 0 && k_idx < NB) ? DW'(drv_b >> (k_idx * DW)) : '0;

    serial_comparator_multi_digit #(
      .WIDTH    (8),
      .DIGIT_W  (DW),
      .MSB_FIRST(MF),
      .SIGNED   (SG)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
    );

    always @(posedge clk) begin
      if (cnt_clr) rvc <= 8'd0;
      else if (ifc.res_valid) rvc <= rvc + 8'd1;
    end

    assign g_busy[g]  = ifc.busy;
    assign g_rv[g]    = ifc.res_valid;
    assign g_flags[g] = {ifc.a_less_b, ifc.a_eq_b, ifc.a_greater_b};
    assign g_rvc[g]   = rvc;
  end

  // {lt, eq, gt} from whole-operand arithmetic
  function automatic logic [2:0] ref_cmp(input logic [7:0] a, input logic [7:0] b, input bit sg);
    int ia;
    int ib;
    ia = sg ? int'($signed(a)) : int'({24'd0, a});
    ib = sg ? int'($signed(b)) : int'({24'd0, b});
    if (ia < ib) return 3'b100;
    if (ia == ib) return 3'b010;
    return 3'b001;
  endfunction

  task automatic drive(input logic v, input logic ab, input logic [7:0] a, input logic [7:0] b,
                       input int k);
    drv_valid = v;
    drv_abort = ab;
    drv_a     = a;
    drv_b     = b;
    drv_k     = k;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    drv_abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 0);
    drive(0, 0, 8'h00, 8'h00, 0);
    rst = 1'b1;
    for (int g = 0; g < 16; g++) begin
      tests++;
      if ({g_busy[g], g_rv[g], g_flags[g]} !== 5'b00010) begin
        fails++;
        $display("FAIL reset cfg%0d: busy/rv/lt/eq/gt got %b expected 00010", g,
                 {g_busy[g], g_rv[g], g_flags[g]});
      end
    end
  endtask

  task automatic test_msb_unsigned();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 8'hA5, 8'hA3, k);
      tests++;
      if (g_busy[5] !== (k < 3)) begin
        fails++;
        $display("FAIL basic busy beat%0d: got %b expected %b", k, g_busy[5], (k < 3));
      end
      tests++;
      if (g_rv[5] !== (k == 3)) begin
        fails++;
        $display("FAIL basic res_valid beat%0d: got %b expected %b", k, g_rv[5], (k == 3));
      end
    end
    tests++;
    if (g_flags[5] !== 3'b001) begin
      fails++;
      $display("FAIL basic flags: got %b expected 001", g_flags[5]);
    end
    drive(0, 0, 8'h00, 8'h00, 0);
    tests++;
    if ({g_rv[5], g_flags[5]} !== 4'b0001) begin
      fails++;
      $display("FAIL basic hold: rv/flags got %b expected 0001", {g_rv[5], g_flags[5]});
    end
  endtask

  task automatic test_signed_gaps();
    drive(1, 0, 8'h80, 8'h01, 0);
    drive(0, 0, 8'h80, 8'h01, 0);
    tests++;
    if (g_busy[13] !== 1'b1) begin
      fails++;
      $display("FAIL signed busy in gap: got %b expected 1", g_busy[13]);
    end
    drive(1, 0, 8'h80, 8'h01, 1);
    drive(0, 0, 8'h80, 8'h01, 1);
    drive(1, 0, 8'h80, 8'h01, 2);
    drive(1, 0, 8'h80, 8'h01, 3);
    tests++;
    if ({g_rv[13], g_flags[13]} !== 4'b1100) begin
      fails++;
      $display("FAIL signed result: rv/flags got %b expected 1100", {g_rv[13], g_flags[13]});
    end
    tests++;
    if ({g_rv[5], g_flags[5]} !== 4'b1001) begin
      fails++;
      $display("FAIL unsigned same stim: rv/flags got %b expected 1001", {g_rv[5], g_flags[5]});
    end
  endtask

  task automatic test_lsb_first();
    for (int k = 0; k < 4; k++) drive(1, 0, 8'h01, 8'h80, k);
    tests++;
    if ({g_rv[1], g_flags[1]} !== 4'b1100) begin
      fails++;
      $display("FAIL lsb lt: rv/flags got %b expected 1100", {g_rv[1], g_flags[1]});
    end
    for (int k = 0; k < 4; k++) drive(1, 0, 8'h3C, 8'h3C, k);
    tests++;
    if ({g_rv[1], g_flags[1]} !== 4'b1010) begin
      fails++;
      $display("FAIL lsb eq: rv/flags got %b expected 1010", {g_rv[1], g_flags[1]});
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 8'hFF, 0);
      tests++;
      if ({g_rv[1], g_flags[1]} !== 4'b0010) begin
        fails++;
        $display("FAIL lsb hold%0d: rv/flags got %b expected 0010", i, {g_rv[1], g_flags[1]});
      end
    end
  endtask

  task automatic test_back_to_back();
    int         first;
    int         second;
    int         pulses;
    logic [2:0] f1;
    logic [2:0] f2;
    first  = -1;
    second = -1;
    pulses = 0;
    f1     = 3'b000;
    f2     = 3'b000;
    for (int j = 0; j < 10; j++) begin
      if (j < 8) drive(1, 0, (j < 4) ? 8'h10 : 8'h20, (j < 4) ? 8'h20 : 8'h10, j % 4);
      else drive(0, 0, 8'h00, 8'h00, 0);
      if (g_rv[5]) begin
        pulses++;
        if (first < 0) begin
          first = j;
          f1    = g_flags[5];
        end else begin
          second = j;
          f2     = g_flags[5];
        end
      end
    end
    tests++;
    if (pulses !== 2 || first !== 3 || second !== 7) begin
      fails++;
      $display("FAIL b2b timing: pulses %0d at %0d,%0d expected 2 at 3,7", pulses, first, second);
    end
    tests++;
    if (f1 !== 3'b100 || f2 !== 3'b001) begin
      fails++;
      $display("FAIL b2b flags: got %b,%b expected 100,001", f1, f2);
    end
  endtask

  task automatic test_abort();
    int pulses;
    drive(1, 0, 8'h00, 8'hFF, 0);
    drive(1, 0, 8'h00, 8'hFF, 1);
    drive(0, 1, 8'h00, 8'h00, 0);
    tests++;
    if ({g_busy[5], g_rv[5], g_flags[5]} !== 5'b00001) begin
      fails++;
      $display("FAIL abort idle: busy/rv/flags got %b expected 00001",
               {g_busy[5], g_rv[5], g_flags[5]});
    end
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1, 0, 8'h7F, 8'h7F, k);
      else drive(0, 0, 8'h00, 8'h00, 0);
      if (g_rv[5]) pulses++;
    end
    tests++;
    if (pulses !== 1 || g_flags[5] !== 3'b010) begin
      fails++;
      $display("FAIL abort then frame: pulses %0d flags %b expected 1 and 010", pulses, g_flags[5]);
    end
    // stale partial from this fragment would be GT; the new frame is LT
    drive(1, 0, 8'hFF, 8'h00, 0);
    drive(1, 0, 8'hFF, 8'h00, 1);
    drive(1, 1, 8'h3F, 8'h7F, 0);
    drive(1, 0, 8'h3F, 8'h7F, 1);
    drive(1, 0, 8'h3F, 8'h7F, 2);
    tests++;
    if (g_rv[5] !== 1'b0) begin
      fails++;
      $display("FAIL abort+valid early: rv got %b expected 0", g_rv[5]);
    end
    drive(1, 0, 8'h3F, 8'h7F, 3);
    tests++;
    if ({g_rv[5], g_flags[5]} !== 4'b1100) begin
      fails++;
      $display("FAIL abort+valid result: rv/flags got %b expected 1100", {g_rv[5], g_flags[5]});
    end
  endtask

  task automatic test_reset_mid_frame();
    int pulses;
    for (int k = 0; k < 4; k++) drive(1, 0, 8'h10, 8'h20, k);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 8'h55, 8'h55, k);
      if (g_rv[5]) pulses++;
    end
    rst = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 0);
    rst = 1'b1;
    if (g_rv[5]) pulses++;
    drive(0, 0, 8'h00, 8'h00, 0);
    if (g_rv[5]) pulses++;
    tests++;
    if (pulses !== 0 || {g_busy[5], g_flags[5]} !== 4'b0010) begin
      fails++;
      $display("FAIL rst mid-frame: pulses %0d busy/flags %b expected 0 and 0010", pulses,
               {g_busy[5], g_flags[5]});
    end
    for (int k = 0; k < 3; k++) drive(1, 0, 8'h22, 8'h21, k);
    tests++;
    if (g_rv[5] !== 1'b0) begin
      fails++;
      $display("FAIL rst next frame early: rv got %b expected 0", g_rv[5]);
    end
    drive(1, 0, 8'h22, 8'h21, 3);
    tests++;
    if ({g_rv[5], g_flags[5]} !== 4'b1001) begin
      fails++;
      $display("FAIL rst next frame: rv/flags got %b expected 1001", {g_rv[5], g_flags[5]});
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] bit_sel;
    logic [2:0] exp;
    rst = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 0);
    rst     = 1'b1;
    cnt_clr = 1'b1;
    drive(0, 0, 8'h00, 8'h00, 0);
    cnt_clr = 1'b0;
    for (int f = 0; f < 24; f++) begin
      a = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin
          bit_sel = 8'd1 << $urandom_range(0, 7);
          b       = a ^ bit_sel;
        end
        default: b = 8'($urandom_range(0, 255));
      endcase
      for (int k = 0; k < 8; k++) begin
        drive(1, 0, a, b, k);
        if ($urandom_range(0, 3) == 0) drive(0, 0, 8'h00, 8'h00, 0);
      end
      drive(0, 0, 8'h00, 8'h00, 0);
      for (int g = 0; g < 16; g++) begin
        exp = ref_cmp(a, b, g >= 8);
        tests++;
        if (g_flags[g] !== exp || g_rvc[g] !== 8'd1) begin
          fails++;
          $display("FAIL random cfg%0d A=%h B=%h: flags %b pulses %0d expected %b and 1", g, a, b,
                   g_flags[g], g_rvc[g], exp);
        end
      end
      cnt_clr = 1'b1;
      drive(0, 0, 8'h00, 8'h00, 0);
      cnt_clr = 1'b0;
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b0;
    cnt_clr   = 1'b1;
    drv_valid = 1'b0;
    drv_abort = 1'b0;
    drv_a     = 8'h00;
    drv_b     = 8'h00;
    drv_k     = 0;
    test_reset();
    cnt_clr = 1'b0;
    test_msb_unsigned();
    test_signed_gaps();
    test_lsb_first();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
